// File: rtl/pixart_i2c_target.sv
// I2C target emulating the PixArt IR camera: register writes become cfg strobes,
// and reads of the report window return a 16-byte blob report snapshot.
module pixart_i2c_target #(
    parameter logic [6:0] ADDR        = 7'h58,
    parameter logic [7:0] REPORT_BASE = 8'h36
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_out,
    output logic       i2c_sda_dir,
    input  logic [9:0] blob_x,
    input  logic [9:0] blob_y,
    input  logic [3:0] blob_size,
    input  logic       blob_valid,
    output logic       cfg_wr,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_REG,
        ST_WDATA,
        ST_RDATA,
        ST_WAIT_STOP
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA; idle bus level is high.
    logic [1:0] meta_reg, sync_reg, prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= 2'b11;
            sync_reg <= 2'b11;
            prev_reg <= 2'b11;
        end else begin
            meta_reg <= {i2c_sda_in, i2c_scl};
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;
    assign sda_s     = sync_reg[1];
    assign scl_rise  = sync_reg[0] & ~prev_reg[0];
    assign scl_fall  = ~sync_reg[0] & prev_reg[0];
    assign start_det = sync_reg[0] & prev_reg[0] & prev_reg[1] & ~sync_reg[1];
    assign stop_det  = sync_reg[0] & prev_reg[0] & ~prev_reg[1] & sync_reg[1];

    state_t      state_reg;
    logic [3:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  tx_reg;
    logic [7:0]  ptr_reg;
    logic        sda_dir_reg;
    logic        busy_reg;
    logic        cfg_wr_reg;
    logic [7:0]  cfg_addr_reg;
    logic [7:0]  cfg_data_reg;
    logic [9:0]  snap_x_reg;
    logic [9:0]  snap_y_reg;
    logic [3:0]  snap_size_reg;
    logic        snap_valid_reg;

    logic [7:0] rd_index;
    logic [7:0] rd_byte;
    assign rd_index = ptr_reg - REPORT_BASE;

    // Without a blob the coordinate bytes read all-ones so the initiator decodes 1023.
    always_comb begin
        rd_byte = 8'h00;
        if (rd_index < 8'd16) begin
            case (rd_index)
                8'd0:    rd_byte = 8'h00;
                8'd1:    rd_byte = snap_valid_reg ? snap_x_reg[7:0] : 8'hFF;
                8'd2:    rd_byte = snap_valid_reg ? snap_y_reg[7:0] : 8'hFF;
                8'd3:    rd_byte = snap_valid_reg ?
                                   {snap_y_reg[9:8], snap_x_reg[9:8], snap_size_reg} : 8'hFF;
                default: rd_byte = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 8'h00;
            tx_reg         <= 8'h00;
            ptr_reg        <= 8'h00;
            sda_dir_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            cfg_wr_reg     <= 1'b0;
            cfg_addr_reg   <= 8'h00;
            cfg_data_reg   <= 8'h00;
            snap_x_reg     <= 10'd0;
            snap_y_reg     <= 10'd0;
            snap_size_reg  <= 4'd0;
            snap_valid_reg <= 1'b0;
        end else begin
            cfg_wr_reg <= 1'b0;
            if (start_det) begin
                state_reg   <= ST_ADDR;
                bit_cnt_reg <= 4'd0;
                sda_dir_reg <= 1'b0;
                busy_reg    <= 1'b0;
            end else if (stop_det) begin
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= 4'd0;
                sda_dir_reg <= 1'b0;
                busy_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        // bit_cnt 8 = ACK being driven, 9 = ACK clock has risen
                        if (scl_rise) begin
                            if (bit_cnt_reg < 4'd8) begin
                                shift_reg   <= {shift_reg[6:0], sda_s};
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end else begin
                                bit_cnt_reg <= 4'd9;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt_reg == 4'd8) begin
                                if (state_reg == ST_ADDR) begin
                                    if (shift_reg[7:1] == ADDR) begin
                                        sda_dir_reg <= 1'b1;
                                        busy_reg    <= 1'b1;
                                        if (shift_reg[0]) begin
                                            snap_x_reg     <= blob_x;
                                            snap_y_reg     <= blob_y;
                                            snap_size_reg  <= blob_size;
                                            snap_valid_reg <= blob_valid;
                                        end
                                    end else begin
                                        state_reg <= ST_WAIT_STOP;
                                    end
                                end else if (state_reg == ST_REG) begin
                                    ptr_reg     <= shift_reg;
                                    sda_dir_reg <= 1'b1;
                                end else begin
                                    cfg_wr_reg   <= 1'b1;
                                    cfg_addr_reg <= ptr_reg;
                                    cfg_data_reg <= shift_reg;
                                    sda_dir_reg  <= 1'b1;
                                end
                            end else if (bit_cnt_reg == 4'd9) begin
                                bit_cnt_reg <= 4'd0;
                                sda_dir_reg <= 1'b0;
                                if (state_reg == ST_ADDR) begin
                                    if (shift_reg[0]) begin
                                        state_reg   <= ST_RDATA;
                                        tx_reg      <= rd_byte;
                                        sda_dir_reg <= ~rd_byte[7];
                                    end else begin
                                        state_reg <= ST_REG;
                                    end
                                end else if (state_reg == ST_REG) begin
                                    state_reg <= ST_WDATA;
                                end else begin
                                    ptr_reg <= ptr_reg + 8'd1;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            if (bit_cnt_reg < 4'd8) begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end else if (bit_cnt_reg == 4'd8) begin
                                if (!sda_s) begin
                                    ptr_reg     <= ptr_reg + 8'd1;
                                    bit_cnt_reg <= 4'd9;
                                end else begin
                                    state_reg   <= ST_WAIT_STOP;
                                    busy_reg    <= 1'b0;
                                    sda_dir_reg <= 1'b0;
                                end
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt_reg >= 4'd1 && bit_cnt_reg <= 4'd7) begin
                                tx_reg      <= {tx_reg[6:0], 1'b1};
                                sda_dir_reg <= ~tx_reg[6];
                            end else if (bit_cnt_reg == 4'd8) begin
                                sda_dir_reg <= 1'b0;
                            end else if (bit_cnt_reg == 4'd9) begin
                                tx_reg      <= rd_byte;
                                sda_dir_reg <= ~rd_byte[7];
                                bit_cnt_reg <= 4'd0;
                            end
                        end
                    end
                    default: begin
                        sda_dir_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign i2c_sda_out = 1'b0;
    assign i2c_sda_dir = sda_dir_reg;
    assign busy        = busy_reg;
    assign cfg_wr      = cfg_wr_reg;
    assign cfg_addr    = cfg_addr_reg;
    assign cfg_data    = cfg_data_reg;

endmodule

// File: tb/tb_pixart_i2c_target.sv
// Bench for pixart_i2c_target: bit-banged I2C initiator, vector table, randomized
// transactions checked against a report/pointer model.
module tb_pixart_i2c_target;

    localparam logic [6:0] DUT_ADDR = 7'h58;
    localparam int         BASE     = 'h36;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m, sda_line;
    logic       i2c_sda_out, i2c_sda_dir;
    logic [9:0] bx, by;
    logic [3:0] bs;
    logic       bv;
    logic       cfg_wr, busy;
    logic [7:0] cfg_addr, cfg_data;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] cfg_q[$];
    bit          busy_seen;
    logic [7:0]  mptr;

    typedef struct {
        bit           rd;
        logic [6:0]   addr;
        logic [7:0]   ptr;
        int           n;
        logic [15:0]  wdat;
        logic [9:0]   x;
        logic [9:0]   y;
        logic [3:0]   sz;
        bit           v;
        bit           exp_ack;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;
    assign sda_line = sda_m & ~i2c_sda_dir;

    pixart_i2c_target dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_scl    (scl_m),
        .i2c_sda_in (sda_line),
        .i2c_sda_out(i2c_sda_out),
        .i2c_sda_dir(i2c_sda_dir),
        .blob_x     (bx),
        .blob_y     (by),
        .blob_size  (bs),
        .blob_valid (bv),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (cfg_wr) cfg_q.push_back({cfg_addr, cfg_data});
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic qwait();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic wbit(input logic b);
        sda_m = b;    qwait();
        scl_m = 1'b1; qwait();
        qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        b = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic wbyte(input logic [7:0] d, output bit ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        ack = ~b;
    endtask

    task automatic rbyte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(~ack);
    endtask

    task automatic xfer_write(input logic [6:0] a, input logic [7:0] r, input int n,
                              input logic [15:0] wd, output bit addr_ack, output bit all_ack);
        bit ack;
        cfg_q.delete();
        busy_seen = 1'b0;
        bus_start();
        wbyte({a, 1'b0}, addr_ack);
        all_ack = addr_ack;
        if (addr_ack) begin
            wbyte(r, ack);
            all_ack &= ack;
            for (int k = 0; k < n; k++) begin
                wbyte(wd[15-8*k -: 8], ack);
                all_ack &= ack;
            end
        end
        bus_stop();
        repeat (4) @(posedge clk);
        #1;
        $display("xfer wr addr=%h reg=%h n=%0d addr_ack=%0d cfg_writes=%0d",
                 a, r, n, addr_ack, cfg_q.size());
    endtask

    task automatic xfer_read(input bit set_ptr, input logic [7:0] r, input int n,
                             output bit addr_ack, output logic [127:0] got);
        bit         ack;
        logic [7:0] b;
        cfg_q.delete();
        got = '0;
        if (set_ptr) begin
            bus_start();
            wbyte({DUT_ADDR, 1'b0}, ack);
            wbyte(r, ack);
        end
        bus_start();
        wbyte({DUT_ADDR, 1'b1}, addr_ack);
        if (addr_ack) begin
            chk("busy_after_ack", 128'(busy), 128'(1'b1));
            for (int k = 0; k < n; k++) begin
                rbyte(b, k != n - 1);
                got[127-8*k -: 8] = b;
                if (k == 1) begin
                    bx = 10'($urandom);
                    by = 10'($urandom);
                    bs = 4'($urandom);
                    bv = 1'($urandom);
                end
            end
            chk("busy_after_nack", 128'(busy), 128'd0);
        end
        bus_stop();
        repeat (4) @(posedge clk);
        #1;
        chk("rd_no_cfg", 128'(cfg_q.size()), 128'd0);
        $display("xfer rd set_ptr=%0d reg=%h n=%0d addr_ack=%0d data=%h",
                 set_ptr, r, n, addr_ack, got);
    endtask

    // Report model: 16-byte window built from the latched blob, zeros outside it.
    function automatic logic [7:0] model_byte(input logic [7:0] ptr, input int x, input int y,
                                              input int s, input bit v);
        logic [7:0] rep[16];
        int         idx;
        for (int k = 0; k < 16; k++) rep[k] = 8'hFF;
        rep[0] = 8'h00;
        if (v) begin
            rep[1] = 8'(x % 256);
            rep[2] = 8'(y % 256);
            rep[3] = 8'((y / 256) * 64 + (x / 256) * 16 + s);
        end
        idx = (int'(ptr) - BASE + 256) % 256;
        return (idx < 16) ? rep[idx] : 8'h00;
    endfunction

    initial begin
        bit           aa, al;
        logic [127:0] got, exp;
        logic [7:0]   r, p;
        logic [6:0]   a;
        logic [15:0]  wd;
        int           n, op, sx, sy, ss;
        bit           sv;

        tbl[0] = '{1'b0, 7'h58, 8'h30, 1, 16'h0100, 10'd0, 10'd0, 4'd0, 1'b0, 1'b1,
                   {16'h3001, 112'd0}};
        tbl[1] = '{1'b0, 7'h58, 8'h06, 2, 16'h90C0, 10'd0, 10'd0, 4'd0, 1'b0, 1'b1,
                   {32'h0690_07C0, 96'd0}};
        tbl[2] = '{1'b0, 7'h21, 8'h00, 0, 16'h0000, 10'd0, 10'd0, 4'd0, 1'b0, 1'b0, 128'd0};
        tbl[3] = '{1'b1, 7'h58, 8'h36, 16, 16'h0000, 10'h123, 10'h2AB, 4'd5, 1'b1, 1'b1,
                   128'h0023AB95_FFFFFFFF_FFFFFFFF_FFFFFFFF};
        tbl[4] = '{1'b1, 7'h58, 8'h36, 16, 16'h0000, 10'h123, 10'h2AB, 4'd5, 1'b0, 1'b1,
                   128'h00FFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF};
        tbl[5] = '{1'b0, 7'h58, 8'hFF, 2, 16'h1234, 10'd0, 10'd0, 4'd0, 1'b0, 1'b1,
                   {32'hFF12_0034, 96'd0}};

        reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        bx = '0; by = '0; bs = '0; bv = 1'b0;
        mptr = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sda_dir", 128'(i2c_sda_dir), 128'd0);
        chk("rst_sda_out", 128'(i2c_sda_out), 128'd0);
        chk("rst_outputs", 128'({cfg_wr, cfg_addr, cfg_data, busy}), 128'd0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            bx = tbl[i].x; by = tbl[i].y; bs = tbl[i].sz; bv = tbl[i].v;
            if (tbl[i].rd) begin
                xfer_read(1'b1, tbl[i].ptr, tbl[i].n, aa, got);
                chk("vec_rd_ack", 128'(aa), 128'(tbl[i].exp_ack));
                chk("vec_rd_bytes", got, tbl[i].exp);
                mptr = tbl[i].ptr + 8'(tbl[i].n - 1);
            end else begin
                xfer_write(tbl[i].addr, tbl[i].ptr, tbl[i].n, tbl[i].wdat, aa, al);
                chk("vec_wr_addr_ack", 128'(aa), 128'(tbl[i].exp_ack));
                chk("vec_wr_all_ack", 128'(al), 128'(tbl[i].exp_ack));
                chk("vec_wr_busy_seen", 128'(busy_seen), 128'(tbl[i].exp_ack));
                chk("vec_cfg_count", 128'(cfg_q.size()), 128'(tbl[i].n));
                got = '0;
                for (int k = 0; k < cfg_q.size() && k < 8; k++) got[127-16*k -: 16] = cfg_q[k];
                chk("vec_cfg_data", got, tbl[i].exp);
                if (tbl[i].exp_ack) mptr = tbl[i].ptr + 8'(tbl[i].n);
            end
        end

        // Reset asserted while the target drives the address ACK of a read.
        bus_start();
        for (int i = 7; i >= 0; i--) wbit(i == 0 ? 1'b1 : DUT_ADDR[i-1]);
        chk("rd_ack_driven", 128'(i2c_sda_dir), 128'(1'b1));
        chk("rd_busy_at_ack", 128'(busy), 128'(1'b1));
        reset = 1'b0;
        #1;
        chk("rst_mid_release", 128'(i2c_sda_dir), 128'd0);
        chk("rst_mid_busy", 128'(busy), 128'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (10) @(posedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        xfer_write(DUT_ADDR, 8'h10, 1, 16'hA500, aa, al);
        chk("post_rst_ack", 128'({aa, al}), 128'(2'b11));
        chk("post_rst_cfg", 128'(cfg_q.size() == 1 ? cfg_q[0] : 16'h0000), 128'(16'h10A5));
        mptr = 8'h11;

        for (int t = 0; t < 24; t++) begin
            op = $urandom_range(0, 3);
            if (op == 0) begin
                r  = 8'($urandom);
                n  = $urandom_range(0, 2);
                wd = 16'($urandom);
                xfer_write(DUT_ADDR, r, n, wd, aa, al);
                exp = '0;
                p = r;
                for (int k = 0; k < n; k++) begin
                    exp[127-16*k -: 16] = {p, wd[15-8*k -: 8]};
                    p = p + 8'd1;
                end
                mptr = p;
                got = '0;
                for (int k = 0; k < cfg_q.size() && k < 8; k++) got[127-16*k -: 16] = cfg_q[k];
                chk("rnd_wr_ack", 128'({aa, al}), 128'(2'b11));
                chk("rnd_cfg_count", 128'(cfg_q.size()), 128'(n));
                chk("rnd_cfg_data", got, exp);
            end else if (op == 1) begin
                a = 7'($urandom);
                if (a == DUT_ADDR) a = a + 7'd1;
                xfer_write(a, 8'($urandom), 1, 16'($urandom), aa, al);
                chk("rnd_miss_ack", 128'(aa), 128'd0);
                chk("rnd_miss_busy", 128'(busy_seen), 128'd0);
                chk("rnd_miss_cfg", 128'(cfg_q.size()), 128'd0);
            end else begin
                r  = 8'(BASE - 2 + int'($urandom_range(0, 20)));
                n  = $urandom_range(1, 5);
                bx = 10'($urandom); by = 10'($urandom); bs = 4'($urandom); bv = 1'($urandom);
                sx = int'(bx); sy = int'(by); ss = int'(bs); sv = bv;
                p  = (op == 2) ? r : mptr;
                xfer_read(op == 2, r, n, aa, got);
                exp = '0;
                for (int k = 0; k < n; k++) begin
                    exp[127-8*k -: 8] = model_byte(p, sx, sy, ss, sv);
                    if (k < n - 1) p = p + 8'd1;
                end
                mptr = p;
                chk("rnd_rd_ack", 128'(aa), 128'(1'b1));
                chk("rnd_rd_bytes", got, exp);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
